lsu_ctrl: RTL and testbench

Load/store control unit directly downstream of dispatch. Takes one decoded memory operation per cycle, with address, byte mask and 64-bit lane-aligned store data already computed by dispatch, and drives a single in-order 64-bit memory bus. It tracks up to `OUTSTANDING_DEPTH` granted transactions, then extracts, sign- or zero-extends and registers load data for register writeback. Misaligned operations are filtered upstream and never reach this block.

---
 rtl/lsu_pkg.sv | 27 ++
 rtl/lsu_pend_fifo.sv | 78 +++++++
 rtl/lsu_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store control unit.
//   lsu_size_e  - access size of a load (byte / half / word)
//   lsu_pend_t  - bookkeeping kept for every granted bus transaction
//   LSU_BUS_BYTES     - byte lanes on the memory bus
//   LSU_MAX_RD_WIDTH  - storage width of the destination register index; any
//                       REG_ADDR_WIDTH up to this value fits in lsu_pend_t.
package lsu_pkg;

    localparam int LSU_BUS_BYTES    = 8;
    localparam int LSU_MAX_RD_WIDTH = 8;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } lsu_size_e;

    typedef struct packed {
        logic                        is_load;
        lsu_size_e                   size;
        logic                        sign;
        logic [2:0]                  offset;
        logic [LSU_MAX_RD_WIDTH-1:0] rd;
        logic                        kill;
    } lsu_pend_t;

endpackage

// File: rtl/lsu_pend_fifo.sv
// lsu_pend_fifo: in-order queue of granted-but-unanswered bus transactions.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   push_i/data_i - enqueue one entry
//   pop_i/data_o  - dequeue the head entry (data_o is the current head)
//   kill_all_i    - mark every stored entry as killed
//   full_o, empty_o, count_o - occupancy status
// Push and pop in the same cycle are allowed at any occupancy, including full.
module lsu_pend_fifo
    import lsu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     kill_all_i,
    input  lsu_pend_t                data_i,
    output lsu_pend_t                data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok, pop_ok;
    lsu_pend_t     ent [DEPTH];

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    // A full queue still takes a push when the head leaves in the same cycle.
    assign push_ok = push_i & (~full_o | pop_i);
    assign pop_ok  = pop_i & ~empty_o;
    assign data_o  = ent[rd_ptr_q];

    // Entries need a reset and a bulk kill, so they live in flops.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_ent
            lsu_pend_t ent_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ent_q <= '0;
                end else if (push_ok && wr_ptr_q == AW'(gi)) begin
                    ent_q <= data_i;
                end else if (kill_all_i) begin
                    ent_q.kill <= 1'b1;
                end
            end
            assign ent[gi] = ent_q;
        end
    endgenerate

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store control unit between dispatch and a 64-bit in-order bus.
// Ports:
//   clk, rst_n                     - clock, asynchronous active-low reset
//   req_mem_i, mem_op_*_i, mem_addr_i, mem_wmask_i, mem_wdata_i, mem_rd_i
//                                  - decoded memory operation from dispatch
//   mem_ready_o                    - operation accepted when high with req_mem_i
//   flush_i                        - drop ungranted work, kill outstanding loads
//   bus_req_o/we/addr/be/wdata_o, bus_gnt_i, bus_rvalid_i, bus_rdata_i
//                                  - memory bus (one response per grant, in order)
//   wb_valid_o, wb_rd_o, wb_data_o - registered load writeback pulse
//   busy_o                         - issue slot or pending queue non-empty
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int OUTSTANDING_DEPTH = 2,
    parameter int REG_ADDR_WIDTH    = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_mem_i,
    input  logic                      mem_op_load_i,
    input  logic                      mem_op_store_i,
    input  logic                      mem_op_lb_i,
    input  logic                      mem_op_lh_i,
    input  logic                      mem_op_lw_i,
    input  logic                      mem_op_lbu_i,
    input  logic                      mem_op_lhu_i,
    input  logic [31:0]               mem_addr_i,
    input  logic [7:0]                mem_wmask_i,
    input  logic [63:0]               mem_wdata_i,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd_i,
    output logic                      mem_ready_o,
    input  logic                      flush_i,
    output logic                      bus_req_o,
    output logic                      bus_we_o,
    output logic [31:0]               bus_addr_o,
    output logic [7:0]                bus_be_o,
    output logic [63:0]               bus_wdata_o,
    input  logic                      bus_gnt_i,
    input  logic                      bus_rvalid_i,
    input  logic [63:0]               bus_rdata_i,
    output logic                      wb_valid_o,
    output logic [REG_ADDR_WIDTH-1:0] wb_rd_o,
    output logic [31:0]               wb_data_o,
    output logic                      busy_o
);

    localparam int CW = $clog2(OUTSTANDING_DEPTH) + 1;

    // Issue slot
    logic        slot_valid_q, slot_valid_d;
    logic        slot_we_q, slot_we_d;
    logic [31:0] slot_addr_q, slot_addr_d;
    logic [7:0]  slot_be_q, slot_be_d;
    logic [63:0] slot_wdata_q, slot_wdata_d;
    lsu_pend_t   slot_info_q, slot_info_d;

    // Writeback
    logic                      wb_valid_q;
    logic [REG_ADDR_WIDTH-1:0] wb_rd_q;
    logic [31:0]               wb_data_q;

    // Pending queue
    lsu_pend_t   q_head, q_push_ent;
    logic        q_push, q_pop, q_full, q_empty;
    logic [CW-1:0] q_count;

    logic        accept, mem_ready, wb_fire;
    int          occ_after;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_word, ld_data;
    logic        unused_ok;

    assign q_push = bus_gnt_i & slot_valid_q;   // grant without a request is ignored
    assign q_pop  = bus_rvalid_i & ~q_empty;     // stray response is ignored

    // The grant push is counted with the pop so a newly accepted op can never
    // find the queue full when its own grant arrives.
    always_comb begin
        occ_after = int'(q_count) - int'(q_pop) + int'(q_push);
    end

    assign mem_ready = (~slot_valid_q | bus_gnt_i) & (occ_after < OUTSTANDING_DEPTH);
    assign accept    = req_mem_i & mem_ready & ~flush_i;

    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_we_d    = slot_we_q;
        slot_addr_d  = slot_addr_q;
        slot_be_d    = slot_be_q;
        slot_wdata_d = slot_wdata_q;
        slot_info_d  = slot_info_q;
        if (accept) begin
            slot_valid_d        = 1'b1;
            slot_we_d           = mem_op_store_i;
            slot_addr_d         = {mem_addr_i[31:3], 3'b000};
            slot_be_d           = mem_op_load_i ? 8'hFF : mem_wmask_i;
            slot_wdata_d        = mem_wdata_i;
            slot_info_d.is_load = mem_op_load_i;
            if (mem_op_lb_i | mem_op_lbu_i) begin
                slot_info_d.size = BYTE;
            end else if (mem_op_lh_i | mem_op_lhu_i) begin
                slot_info_d.size = HALF;
            end else if (mem_op_lw_i) begin
                slot_info_d.size = WORD;
            end else begin
                slot_info_d.size = WORD;
            end
            slot_info_d.sign   = mem_op_lb_i | mem_op_lh_i;
            slot_info_d.offset = mem_addr_i[2:0];
            slot_info_d.rd     = LSU_MAX_RD_WIDTH'(mem_rd_i);
            slot_info_d.kill   = 1'b0;
        end else if (q_push | flush_i) begin
            slot_valid_d = 1'b0;
        end
    end

    // A grant landing in the flush cycle enters the queue already killed.
    always_comb begin
        q_push_ent      = slot_info_q;
        q_push_ent.kill = flush_i;
    end

    lsu_pend_fifo #(.DEPTH(OUTSTANDING_DEPTH)) u_pend (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (q_push),
        .pop_i     (q_pop),
        .kill_all_i(flush_i),
        .data_i    (q_push_ent),
        .data_o    (q_head),
        .full_o    (q_full),
        .empty_o   (q_empty),
        .count_o   (q_count)
    );

    // Load extraction from the 64-bit response
    always_comb begin
        ld_byte = bus_rdata_i[{q_head.offset, 3'b000} +: 8];
        ld_half = bus_rdata_i[{q_head.offset[2:1], 4'b0000} +: 16];
        ld_word = bus_rdata_i[{q_head.offset[2], 5'b00000} +: 32];
        case (q_head.size)
            BYTE:    ld_data = q_head.sign ? {{24{ld_byte[7]}}, ld_byte} : {24'h0, ld_byte};
            HALF:    ld_data = q_head.sign ? {{16{ld_half[15]}}, ld_half} : {16'h0, ld_half};
            default: ld_data = ld_word;
        endcase
    end

    // A pop coinciding with flush belongs to the flushed work.
    assign wb_fire = q_pop & q_head.is_load & ~q_head.kill & ~flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid_q <= 1'b0;
            slot_we_q    <= 1'b0;
            slot_addr_q  <= '0;
            slot_be_q    <= '0;
            slot_wdata_q <= '0;
            slot_info_q  <= '0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
        end else begin
            slot_valid_q <= slot_valid_d;
            slot_we_q    <= slot_we_d;
            slot_addr_q  <= slot_addr_d;
            slot_be_q    <= slot_be_d;
            slot_wdata_q <= slot_wdata_d;
            slot_info_q  <= slot_info_d;
            wb_valid_q   <= wb_fire;
            if (wb_fire) begin
                wb_rd_q   <= q_head.rd[REG_ADDR_WIDTH-1:0];
                wb_data_q <= ld_data;
            end
        end
    end

    assign mem_ready_o = mem_ready;
    assign bus_req_o   = slot_valid_q;
    assign bus_we_o    = slot_we_q;
    assign bus_addr_o  = slot_addr_q;
    assign bus_be_o    = slot_be_q;
    assign bus_wdata_o = slot_wdata_q;
    assign wb_valid_o  = wb_valid_q;
    assign wb_rd_o     = wb_rd_q;
    assign wb_data_o   = wb_data_q;
    assign busy_o      = slot_valid_q | ~q_empty;

    // Upper rd storage bits and the full flag are not needed here.
    assign unused_ok = ^{q_head.rd, q_full};

    a_rvalid_has_entry: assert property (@(posedge clk) disable iff (!rst_n)
        bus_rvalid_i |-> !q_empty)
        else $error("lsu_ctrl: bus_rvalid_i with no outstanding transaction");

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: self-checking bench for lsu_ctrl with a writeback scoreboard.
module tb_lsu_ctrl;

    localparam int K_LB = 0, K_LH = 1, K_LW = 2, K_LBU = 3, K_LHU = 4, K_SW = 5;

    logic        clk, rst_n;
    logic        req_mem_i, mem_op_load_i, mem_op_store_i;
    logic        mem_op_lb_i, mem_op_lh_i, mem_op_lw_i, mem_op_lbu_i, mem_op_lhu_i;
    logic [31:0] mem_addr_i;
    logic [7:0]  mem_wmask_i;
    logic [63:0] mem_wdata_i;
    logic [4:0]  mem_rd_i;
    logic        mem_ready_o, flush_i;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o;
    logic [7:0]  bus_be_o;
    logic [63:0] bus_wdata_o;
    logic        bus_gnt_i, bus_rvalid_i;
    logic [63:0] bus_rdata_i;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        busy_o;

    lsu_ctrl #(.OUTSTANDING_DEPTH(2), .REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_mem_i(req_mem_i), .mem_op_load_i(mem_op_load_i), .mem_op_store_i(mem_op_store_i),
        .mem_op_lb_i(mem_op_lb_i), .mem_op_lh_i(mem_op_lh_i), .mem_op_lw_i(mem_op_lw_i),
        .mem_op_lbu_i(mem_op_lbu_i), .mem_op_lhu_i(mem_op_lhu_i),
        .mem_addr_i(mem_addr_i), .mem_wmask_i(mem_wmask_i), .mem_wdata_i(mem_wdata_i),
        .mem_rd_i(mem_rd_i), .mem_ready_o(mem_ready_o), .flush_i(flush_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o), .bus_gnt_i(bus_gnt_i),
        .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
        .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
        .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks_cnt = 0;
    int errors_cnt = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_exp_t;

    wb_exp_t sb[$];
    wb_exp_t mon_e;

    // Reference extraction: shift the addressed byte down to bit 0, then extend.
    function automatic logic [31:0] exp_load(input int kind, input logic [31:0] addr,
                                             input logic [63:0] rdata);
        logic [63:0] sh;
        sh = rdata >> (addr[2:0] * 8);
        case (kind)
            K_LB:    return {{24{sh[7]}}, sh[7:0]};
            K_LH:    return {{16{sh[15]}}, sh[15:0]};
            K_LBU:   return {24'h0, sh[7:0]};
            K_LHU:   return {16'h0, sh[15:0]};
            default: return sh[31:0];
        endcase
    endfunction

    task automatic expect_wb(input int kind, input logic [31:0] addr, input logic [4:0] rd,
                             input logic [63:0] rdata);
        wb_exp_t e;
        if (kind != K_SW) begin
            e.rd   = rd;
            e.data = exp_load(kind, addr, rdata);
            sb.push_back(e);
        end
    endtask

    // Writeback monitor: every pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && wb_valid_o === 1'b1) begin
            if (sb.size() == 0) begin
                check_eq("wb_unexpected", {63'h0, wb_valid_o}, 64'h0);
            end else begin
                mon_e = sb.pop_front();
                check_eq("wb_rd", {59'h0, wb_rd_o}, {59'h0, mon_e.rd});
                check_eq("wb_data", {32'h0, wb_data_o}, {32'h0, mon_e.data});
                $display("wb rd=%0d data=0x%08h", wb_rd_o, wb_data_o);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input int kind, input logic [31:0] addr, input logic [7:0] wmask,
                            input logic [63:0] wdata, input logic [4:0] rd);
        req_mem_i      = 1'b1;
        mem_op_store_i = (kind == K_SW);
        mem_op_load_i  = (kind != K_SW);
        mem_op_lb_i    = (kind == K_LB);
        mem_op_lh_i    = (kind == K_LH);
        mem_op_lw_i    = (kind == K_LW);
        mem_op_lbu_i   = (kind == K_LBU);
        mem_op_lhu_i   = (kind == K_LHU);
        mem_addr_i     = addr;
        mem_wmask_i    = (kind == K_SW) ? wmask : 8'h00;
        mem_wdata_i    = wdata;
        mem_rd_i       = rd;
    endtask

    task automatic drop_op();
        req_mem_i = 1'b0; mem_op_store_i = 1'b0; mem_op_load_i = 1'b0;
        mem_op_lb_i = 1'b0; mem_op_lh_i = 1'b0; mem_op_lw_i = 1'b0;
        mem_op_lbu_i = 1'b0; mem_op_lhu_i = 1'b0;
        mem_addr_i = '0; mem_wmask_i = '0; mem_wdata_i = '0; mem_rd_i = '0;
    endtask

    // One op with immediate grant and immediate response.
    task automatic run_op(input int kind, input logic [31:0] addr, input logic [7:0] wmask,
                          input logic [63:0] wdata, input logic [4:0] rd, input logic [63:0] rdata);
        next_cycle();
        drive_op(kind, addr, wmask, wdata, rd);
        @(negedge clk);
        check_eq("op_ready", {63'h0, mem_ready_o}, 64'h1);
        next_cycle();
        drop_op();
        bus_gnt_i = 1'b1;
        @(negedge clk);
        check_eq("op_bus_req", {63'h0, bus_req_o}, 64'h1);
        check_eq("op_bus_addr", {32'h0, bus_addr_o}, {32'h0, addr[31:3], 3'b000});
        check_eq("op_bus_be", {56'h0, bus_be_o}, {56'h0, (kind == K_SW) ? wmask : 8'hFF});
        check_eq("op_bus_we", {63'h0, bus_we_o}, {63'h0, kind == K_SW});
        if (kind == K_SW) check_eq("op_bus_wdata", bus_wdata_o, wdata);
        next_cycle();
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = rdata;
        expect_wb(kind, addr, rd, rdata);
        @(negedge clk);
        check_eq("op_req_drop", {63'h0, bus_req_o}, 64'h0);
        next_cycle();
        bus_rvalid_i = 1'b0;
        @(negedge clk);
        check_eq("op_wb_pulse", {63'h0, wb_valid_o}, {63'h0, kind != K_SW});
        #1;
        check_eq("op_sb_drained", 64'(sb.size()), 64'h0);
        check_eq("op_idle", {63'h0, busy_o}, 64'h0);
        $display("op kind=%0d addr=0x%08h rd=%0d rdata=0x%016h", kind, addr, rd, rdata);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          kind;
        logic [31:0] addr;
        logic [63:0] rdata;

        rst_n = 1'b0;
        drop_op();
        flush_i = 1'b0; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_bus_ctl", {54'h0, bus_req_o, bus_we_o, bus_be_o}, 64'h0);
        check_eq("rst_bus_addr", {32'h0, bus_addr_o}, 64'h0);
        check_eq("rst_bus_wdata", bus_wdata_o, 64'h0);
        check_eq("rst_wb", {26'h0, wb_valid_o, wb_rd_o, wb_data_o}, 64'h0);
        check_eq("rst_ready", {63'h0, mem_ready_o}, 64'h1);
        check_eq("rst_busy", {63'h0, busy_o}, 64'h0);
        next_cycle();
        rst_n = 1'b1;

        // Directed extraction and store cases
        run_op(K_LB,  32'h0000_1003, 8'h00, 64'h0, 5'd7, 64'h01234567_80AABBCC);
        run_op(K_LBU, 32'h0000_1003, 8'h00, 64'h0, 5'd7, 64'h01234567_80AABBCC);
        run_op(K_SW,  32'h0000_1004, 8'hF0, 64'hDEADBEEF_00000000, 5'd0, 64'h0);
        run_op(K_LH,  32'h0000_1006, 8'h00, 64'h0, 5'd12, 64'h8001_2222_3333_4444);
        run_op(K_LHU, 32'h0000_1002, 8'h00, 64'h0, 5'd13, 64'h1111_2222_F00D_4444);
        run_op(K_LW,  32'h0000_1004, 8'h00, 64'h0, 5'd31, 64'h89ABCDEF_01234567);

        // Random aligned loads
        for (int i = 0; i < 8; i++) begin
            kind = int'($urandom_range(0, 4));
            addr = 32'h0000_4000 | 32'($urandom_range(0, 7));
            if (kind == K_LH || kind == K_LHU) addr[0] = 1'b0;
            if (kind == K_LW) addr[1:0] = 2'b00;
            rdata = {$urandom, $urandom};
            run_op(kind, addr, 8'h00, 64'h0, 5'($urandom_range(1, 31)), rdata);
        end

        // Grant withheld three cycles while a second op waits
        next_cycle();
        drive_op(K_LW, 32'h0000_2000, 8'h00, 64'h0, 5'd3);
        @(negedge clk);
        check_eq("stall_acc", {63'h0, mem_ready_o}, 64'h1);
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            drive_op(K_LBU, 32'h0000_2001, 8'h00, 64'h0, 5'd4);
            @(negedge clk);
            check_eq("stall_req", {63'h0, bus_req_o}, 64'h1);
            check_eq("stall_addr", {32'h0, bus_addr_o}, 64'h2000);
            check_eq("stall_be", {56'h0, bus_be_o}, 64'hFF);
            check_eq("stall_ready", {63'h0, mem_ready_o}, 64'h0);
        end
        next_cycle();
        bus_gnt_i = 1'b1;
        @(negedge clk);
        check_eq("stall_gnt_ready", {63'h0, mem_ready_o}, 64'h1);
        next_cycle();
        drop_op();
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 64'h0000_0000_CAFE_8899;
        expect_wb(K_LW, 32'h0000_2000, 5'd3, bus_rdata_i);
        @(negedge clk);
        check_eq("stall_second_req", {63'h0, bus_req_o}, 64'h1);
        next_cycle();
        bus_gnt_i   = 1'b0;
        bus_rdata_i = 64'h0000_0000_0000_A500;
        expect_wb(K_LBU, 32'h0000_2001, 5'd4, bus_rdata_i);
        @(negedge clk);
        check_eq("stall_single_txn", {63'h0, bus_req_o}, 64'h0);
        next_cycle();
        bus_rvalid_i = 1'b0;
        @(negedge clk);
        #1;
        check_eq("stall_sb_drained", 64'(sb.size()), 64'h0);
        $display("txn stall sequence done");

        // Queue full: two granted loads, third waits for the first response
        next_cycle();
        drive_op(K_LW, 32'h0000_5000, 8'h00, 64'h0, 5'd1);
        @(negedge clk);
        check_eq("full_acc1", {63'h0, mem_ready_o}, 64'h1);
        next_cycle();
        drive_op(K_LH, 32'h0000_5006, 8'h00, 64'h0, 5'd2);
        bus_gnt_i = 1'b1;
        @(negedge clk);
        check_eq("full_acc2", {63'h0, mem_ready_o}, 64'h1);
        next_cycle();
        drop_op();
        @(negedge clk);
        check_eq("full_addr2", {32'h0, bus_addr_o}, 64'h5000);
        next_cycle();
        bus_gnt_i = 1'b0;
        drive_op(K_LB, 32'h0000_5001, 8'h00, 64'h0, 5'd3);
        @(negedge clk);
        check_eq("full_ready_lo", {63'h0, mem_ready_o}, 64'h0);
        check_eq("full_busy", {63'h0, busy_o}, 64'h1);
        next_cycle();
        @(negedge clk);
        check_eq("full_ready_hold", {63'h0, mem_ready_o}, 64'h0);
        next_cycle();
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 64'h1111_2222_7654_3210;
        expect_wb(K_LW, 32'h0000_5000, 5'd1, bus_rdata_i);
        @(negedge clk);
        check_eq("full_ready_on_pop", {63'h0, mem_ready_o}, 64'h1);
        next_cycle();
        drop_op();
        bus_gnt_i   = 1'b1;
        bus_rdata_i = 64'hFEDC_0000_0000_0000;
        expect_wb(K_LH, 32'h0000_5006, 5'd2, bus_rdata_i);
        @(negedge clk);
        check_eq("full_third_req", {63'h0, bus_req_o}, 64'h1);
        next_cycle();
        bus_gnt_i   = 1'b0;
        bus_rdata_i = 64'h0000_0000_0000_9A00;
        expect_wb(K_LB, 32'h0000_5001, 5'd3, bus_rdata_i);
        next_cycle();
        bus_rvalid_i = 1'b0;
        @(negedge clk);
        #1;
        check_eq("full_sb_drained", 64'(sb.size()), 64'h0);
        check_eq("full_idle", {63'h0, busy_o}, 64'h0);
        $display("txn queue-full sequence done");

        // Flush with a granted load outstanding and a second op in the slot
        next_cycle();
        drive_op(K_LW, 32'h0000_3000, 8'h00, 64'h0, 5'd9);
        next_cycle();
        drive_op(K_LBU, 32'h0000_3005, 8'h00, 64'h0, 5'd10);
        bus_gnt_i = 1'b1;
        next_cycle();
        drive_op(K_LH, 32'h0000_3002, 8'h00, 64'h0, 5'd11);
        bus_gnt_i = 1'b0;
        flush_i   = 1'b1;
        next_cycle();
        drop_op();
        flush_i      = 1'b0;
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 64'h1234_5678_9ABC_DEF0;
        @(negedge clk);
        check_eq("flush_slot_dropped", {63'h0, bus_req_o}, 64'h0);
        check_eq("flush_busy_pending", {63'h0, busy_o}, 64'h1);
        next_cycle();
        bus_rvalid_i = 1'b0;
        @(negedge clk);
        check_eq("flush_no_wb", {63'h0, wb_valid_o}, 64'h0);
        check_eq("flush_idle", {63'h0, busy_o}, 64'h0);
        $display("txn flush with slot dropped done");

        // Grant arriving in the flush cycle
        next_cycle();
        drive_op(K_LB, 32'h0000_3007, 8'h00, 64'h0, 5'd12);
        next_cycle();
        drop_op();
        bus_gnt_i = 1'b1;
        flush_i   = 1'b1;
        next_cycle();
        bus_gnt_i    = 1'b0;
        flush_i      = 1'b0;
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 64'hFF00_0000_0000_0000;
        @(negedge clk);
        check_eq("flush_gnt_busy", {63'h0, busy_o}, 64'h1);
        next_cycle();
        bus_rvalid_i = 1'b0;
        @(negedge clk);
        check_eq("flush_gnt_no_wb", {63'h0, wb_valid_o}, 64'h0);
        check_eq("flush_gnt_idle", {63'h0, busy_o}, 64'h0);
        $display("txn flush with grant done");

        // Reset with two pending loads
        next_cycle();
        drive_op(K_LW, 32'h0000_6000, 8'h00, 64'h0, 5'd20);
        next_cycle();
        drive_op(K_LW, 32'h0000_6008, 8'h00, 64'h0, 5'd21);
        bus_gnt_i = 1'b1;
        next_cycle();
        drop_op();
        next_cycle();
        bus_gnt_i = 1'b0;
        check_eq("pre_rst_busy", {63'h0, busy_o}, 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_bus", {54'h0, bus_req_o, bus_we_o, bus_be_o}, 64'h0);
        check_eq("arst_addr", {32'h0, bus_addr_o}, 64'h0);
        check_eq("arst_wdata", bus_wdata_o, 64'h0);
        check_eq("arst_wb", {26'h0, wb_valid_o, wb_rd_o, wb_data_o}, 64'h0);
        check_eq("arst_busy", {63'h0, busy_o}, 64'h0);
        check_eq("arst_ready", {63'h0, mem_ready_o}, 64'h1);
        next_cycle();
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 64'h0000_0000_1111_2222;
        next_cycle();
        bus_rvalid_i = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("stray_no_wb", {63'h0, wb_valid_o}, 64'h0);
        check_eq("stray_idle", {63'h0, busy_o}, 64'h0);
        $display("txn reset with pending loads done");

        // Normal operation after reset
        run_op(K_LH, 32'h0000_7002, 8'h00, 64'h0, 5'd5, 64'h0000_0000_9876_0000);

        check_eq("final_sb_empty", 64'(sb.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
